// File: rtl/flow_table_ctrl.sv
// Flow-table RAM sequencer: bulk clear after reset or on request, then shares port A
// between host config traffic and port B with the lookup pipeline.
module flow_table_ctrl #(
    parameter int unsigned DWIDTH = 15,
    parameter int unsigned AWIDTH = 6,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    input  logic              cfg_we,
    input  logic [AWIDTH-1:0] cfg_addr,
    input  logic [DWIDTH-1:0] cfg_wdata,
    output logic              cfg_ready,
    output logic              cfg_rvalid,
    output logic [DWIDTH-1:0] cfg_rdata,
    input  logic              lk_valid,
    input  logic [AWIDTH-1:0] lk_addr,
    output logic              lk_ready,
    output logic              lk_rvalid,
    output logic [DWIDTH-1:0] lk_rdata,
    input  logic              clr_req,
    output logic              init_done,
    output logic              ram_we,
    output logic [AWIDTH-1:0] ram_a,
    output logic [AWIDTH-1:0] ram_dpra,
    output logic [DWIDTH-1:0] ram_di,
    input  logic [DWIDTH-1:0] ram_spo,
    input  logic [DWIDTH-1:0] ram_dpo
);

    typedef enum logic {StClear, StServe} state_e;

    localparam logic [AWIDTH-1:0] LastAddr = AWIDTH'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic              cfg_rvalid_q, lk_rvalid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StClear;
            clr_cnt_q    <= '0;
            cfg_rvalid_q <= 1'b0;
            lk_rvalid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            cfg_rvalid_q <= cfg_valid & cfg_ready & ~cfg_we;
            lk_rvalid_q  <= lk_valid & lk_ready;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ram_we    = 1'b0;
        ram_a     = cfg_addr;
        ram_di    = cfg_wdata;
        cfg_ready = 1'b0;
        lk_ready  = 1'b0;
        init_done = 1'b0;
        if (!reset) begin
            case (state_q)
                StClear: begin
                    ram_we = 1'b1;
                    ram_a  = clr_cnt_q;
                    ram_di = '0;
                    if (clr_cnt_q == LastAddr) begin
                        clr_cnt_d = '0;
                        state_d   = StServe;
                    end else begin
                        clr_cnt_d = clr_cnt_q + AWIDTH'(1);
                    end
                end
                StServe: begin
                    init_done = 1'b1;
                    cfg_ready = 1'b1;
                    lk_ready  = 1'b1;
                    ram_we    = cfg_valid & cfg_we;
                    // Requests in the clr_req cycle are still accepted and complete normally.
                    if (clr_req) begin
                        state_d   = StClear;
                        clr_cnt_d = '0;
                    end
                end
                default: state_d = StClear;
            endcase
        end
    end

    assign ram_dpra = lk_addr;

    // An outstanding response is dropped as soon as reset is seen.
    assign cfg_rvalid = cfg_rvalid_q & ~reset;
    assign lk_rvalid  = lk_rvalid_q & ~reset;
    assign cfg_rdata  = ram_spo;
    assign lk_rdata   = ram_dpo;

endmodule

// File: tb/tb_flow_table_ctrl.sv
// Self-checking bench for flow_table_ctrl: behavioural RAM, table-level reference model
// with per-cycle compare, directed scenarios and a randomized phase.
module tb_flow_table_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid, cfg_we;
    logic [5:0]  cfg_addr;
    logic [14:0] cfg_wdata;
    logic        cfg_ready, cfg_rvalid;
    logic [14:0] cfg_rdata;
    logic        lk_valid;
    logic [5:0]  lk_addr;
    logic        lk_ready, lk_rvalid;
    logic [14:0] lk_rdata;
    logic        clr_req, init_done;
    logic        ram_we;
    logic [5:0]  ram_a, ram_dpra;
    logic [14:0] ram_di, ram_spo, ram_dpo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    flow_table_ctrl #(.DWIDTH(15), .AWIDTH(6), .DEPTH(64)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_ready(cfg_ready), .cfg_rvalid(cfg_rvalid), .cfg_rdata(cfg_rdata),
        .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_ready(lk_ready),
        .lk_rvalid(lk_rvalid), .lk_rdata(lk_rdata),
        .clr_req(clr_req), .init_done(init_done),
        .ram_we(ram_we), .ram_a(ram_a), .ram_dpra(ram_dpra), .ram_di(ram_di),
        .ram_spo(ram_spo), .ram_dpo(ram_dpo)
    );

    // Dual-port RAM: registered addresses, async array read, so same-address writes read new.
    logic [14:0] mem [64];
    logic [5:0]  a_q, dpra_q;
    always @(posedge clk) begin
        if (ram_we) mem[ram_a] <= ram_di;
        a_q    <= ram_a;
        dpra_q <= ram_dpra;
    end
    assign ram_spo = mem[a_q];
    assign ram_dpo = mem[dpra_q];

    // Reference model: table contents, clear cycles remaining, expected responses.
    int          clr_left;
    logic [14:0] mt [64];
    logic        cpend, lpend;
    logic [14:0] cdata, ldata;

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = 15'h2AAA;
            mt[i]  = 15'h2AAA;
        end
        clr_left = 64;
        cpend    = 1'b0;
        lpend    = 1'b0;
        cdata    = '0;
        ldata    = '0;
    end

    always @(posedge clk) begin
        if (reset) begin
            clr_left = 64;
            cpend    = 1'b0;
            lpend    = 1'b0;
        end else if (clr_left > 0) begin
            mt[64 - clr_left] = '0;
            clr_left          = clr_left - 1;
            cpend             = 1'b0;
            lpend             = 1'b0;
        end else begin
            if (cfg_valid && cfg_we) mt[cfg_addr] = cfg_wdata;
            cpend = cfg_valid && !cfg_we;
            cdata = mt[cfg_addr];
            lpend = lk_valid;
            ldata = mt[lk_addr];
            if (clr_req) clr_left = 64;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic srv, exp_we;
        srv    = !reset && clr_left == 0;
        exp_we = reset ? 1'b0 : (clr_left > 0) ? 1'b1 : (cfg_valid && cfg_we);
        chk("init_done", 32'(init_done), 32'(srv));
        chk("cfg_ready", 32'(cfg_ready), 32'(srv));
        chk("lk_ready", 32'(lk_ready), 32'(srv));
        chk("ram_we", 32'(ram_we), 32'(exp_we));
        chk("ram_dpra", 32'(ram_dpra), 32'(lk_addr));
        if (!reset && clr_left > 0) begin
            chk("clr_ram_a", 32'(ram_a), 32'(64 - clr_left));
            chk("clr_ram_di", 32'(ram_di), 32'(0));
        end
        if (srv) begin
            chk("srv_ram_a", 32'(ram_a), 32'(cfg_addr));
            chk("srv_ram_di", 32'(ram_di), 32'(cfg_wdata));
        end
        chk("cfg_rvalid", 32'(cfg_rvalid), 32'(!reset && cpend));
        if (!reset && cpend) chk("cfg_rdata", 32'(cfg_rdata), 32'(cdata));
        chk("lk_rvalid", 32'(lk_rvalid), 32'(!reset && lpend));
        if (!reset && lpend) chk("lk_rdata", 32'(lk_rdata), 32'(ldata));
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cfg_valid = 1'b0;
        cfg_we    = 1'b0;
        lk_valid  = 1'b0;
        clr_req   = 1'b0;
    endtask

    // Called just after reset is released; counts clear cycles until init_done rises.
    task automatic wait_init(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!init_done && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk(name, 32'(n), 32'd64);
    endtask

    task automatic lk_lit(input logic [5:0] addr, input logic [14:0] exp, input string name);
        adv();
        lk_valid = 1'b1;
        lk_addr  = addr;
        adv();
        lk_valid = 1'b0;
        @(negedge clk);
        chk(name, 32'({lk_rvalid, lk_rdata}), 32'({1'b1, exp}));
    endtask

    initial begin
        int cnt, k;
        reset     = 1'b1;
        idle();
        cfg_addr  = '0;
        cfg_wdata = '0;
        lk_addr   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        wait_init("init_low_cycles");
        lk_lit(6'd0, 15'h0, "lk0_cleared");
        lk_lit(6'd31, 15'h0, "lk31_cleared");
        lk_lit(6'd63, 15'h0, "lk63_cleared");

        // Host write then read of the same entry.
        adv();
        cfg_valid = 1'b1; cfg_we = 1'b1; cfg_addr = 6'd5; cfg_wdata = 15'h1A5B;
        adv();
        cfg_we = 1'b0;
        @(negedge clk);
        chk("wr_no_rvalid", 32'(cfg_rvalid), 32'd0);
        adv();
        idle();
        @(negedge clk);
        chk("rd_after_wr", 32'({cfg_rvalid, cfg_rdata}), 32'({1'b1, 15'h1A5B}));

        // Same-cycle write and lookup of one address.
        adv();
        cfg_valid = 1'b1; cfg_we = 1'b1; cfg_addr = 6'd9; cfg_wdata = 15'h7FFF;
        lk_valid = 1'b1; lk_addr = 6'd9;
        adv();
        idle();
        @(negedge clk);
        chk("collision_new", 32'({lk_rvalid, lk_rdata}), 32'({1'b1, 15'h7FFF}));

        cnt = 0;
        for (int i = 0; i <= 64; i++) begin
            adv();
            if (i < 64) begin
                lk_valid = 1'b1;
                lk_addr  = 6'(i);
            end else begin
                idle();
            end
            @(negedge clk);
            if (i > 0 && lk_rvalid) cnt++;
        end
        chk("stream_pulses", 32'(cnt), 32'd64);

        // Fill with index, then clear with a concurrent lookup and a stray clr_req mid-clear.
        for (int i = 0; i < 64; i++) begin
            adv();
            cfg_valid = 1'b1; cfg_we = 1'b1; cfg_addr = 6'(i); cfg_wdata = 15'(i);
        end
        adv();
        idle();
        clr_req = 1'b1; lk_valid = 1'b1; lk_addr = 6'd3;
        adv();
        idle();
        @(negedge clk);
        chk("lk_with_clr", 32'({lk_rvalid, lk_rdata}), 32'({1'b1, 15'd3}));
        k = 0;
        while (!lk_ready && k < 200) begin
            k++;
            adv();
            clr_req = (k == 20);
            @(negedge clk);
        end
        chk("clr_ready_low", 32'(k), 32'd64);
        for (int i = 0; i < 64; i++) begin
            adv();
            lk_valid = 1'b1;
            lk_addr  = 6'(i);
        end
        lk_lit(6'd3, 15'h0, "lk3_after_clr");
        lk_lit(6'd63, 15'h0, "lk63_after_clr");

        // Reset mid-clear at clr_cnt = 40.
        adv();
        clr_req = 1'b1;
        adv();
        clr_req = 1'b0;
        repeat (40) adv();
        reset = 1'b1;
        adv();
        reset = 1'b0;
        wait_init("rst_mid_clr_len");

        // Reset one cycle after a lookup accept drops the response.
        adv();
        lk_valid = 1'b1; lk_addr = 6'd7;
        adv();
        lk_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        chk("rst_drop_rvalid", 32'(lk_rvalid), 32'd0);
        adv();
        reset = 1'b0;
        wait_init("rst_after_lk_len");

        // Randomized traffic; narrow address ranges at times to provoke collisions.
        repeat (1500) begin
            adv();
            cfg_valid = 1'($urandom_range(0, 1));
            cfg_we    = 1'($urandom_range(0, 1));
            cfg_addr  = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 3))
                                                    : 6'($urandom_range(0, 63));
            cfg_wdata = 15'($urandom);
            lk_valid  = 1'($urandom_range(0, 1));
            lk_addr   = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 3))
                                                    : 6'($urandom_range(0, 63));
            clr_req   = ($urandom_range(0, 99) == 0);
            reset     = ($urandom_range(0, 399) == 0);
        end
        adv();
        idle();
        reset = 1'b0;
        repeat (70) adv();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flow_table_ctrl.md
Name: flow_table_ctrl

Overview:
- Sequences and shares one flow-table dual-port RAM: registered read addresses, 1-cycle read latency, write-first on same-address collision, DEPTH x DWIDTH.
- Port A (write plus spo read) is shared between the host configuration interface and an internal bulk-clear sweeper.
- Port B (dpra/dpo read-only) serves the packet lookup pipeline.
- Sits between the switch control-register block, the lookup pipeline and the RAM instance.

Parameters:
- DWIDTH, 15, flow entry width.
- AWIDTH, 6, address width.
- DEPTH, 64, number of entries; DEPTH <= 2**AWIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- cfg_valid  in  1  host request valid.
- cfg_we  in  1  1 = write, 0 = read.
- cfg_addr  in  AWIDTH  host address.
- cfg_wdata  in  DWIDTH  host write data.
- cfg_ready  out  1  host request accepted when cfg_valid & cfg_ready.
- cfg_rvalid  out  1  host read data valid, 1-cycle pulse.
- cfg_rdata  out  DWIDTH  host read data.
- lk_valid  in  1  lookup request valid.
- lk_addr  in  AWIDTH  lookup index.
- lk_ready  out  1  lookup accepted when lk_valid & lk_ready.
- lk_rvalid  out  1  lookup data valid, 1-cycle pulse.
- lk_rdata  out  DWIDTH  lookup data.
- clr_req  in  1  pulse: start a bulk clear of the whole table.
- init_done  out  1  high when the table is cleared and serving.
- ram_we  out  1  RAM write enable.
- ram_a  out  AWIDTH  RAM port-A address.
- ram_dpra  out  AWIDTH  RAM port-B address.
- ram_di  out  DWIDTH  RAM write data.
- ram_spo  in  DWIDTH  RAM port-A read data.
- ram_dpo  in  DWIDTH  RAM port-B read data.

Behaviour:
- States are CLEAR and SERVE.
- Reset:
  - While reset is high: state <= CLEAR, clr_cnt <= 0, cfg_rvalid = lk_rvalid = 0, init_done = 0.
  - While reset is high, ram_we, cfg_ready and lk_ready are forced 0.
  - Reset has the same effect at any point mid-operation. Any outstanding read response is dropped; no rvalid is issued for it.
- CLEAR:
  - Each cycle: ram_we = 1, ram_a = clr_cnt, ram_di = 0, then clr_cnt increments.
  - After the write at clr_cnt = DEPTH-1: clr_cnt <= 0 and state <= SERVE. A clear therefore takes exactly DEPTH cycles.
  - cfg_ready = lk_ready = 0 throughout.
  - clr_req is ignored in CLEAR.
- SERVE:
  - init_done = 1, cfg_ready = 1, lk_ready = 1.
  - ram_a = cfg_addr, ram_di = cfg_wdata, ram_we = cfg_valid & cfg_we.
  - ram_dpra = lk_addr unconditionally.
  - clr_req = 1 in SERVE: the concurrent cfg/lk request is still accepted that cycle; state <= CLEAR next cycle and the pending reads complete normally.
- Read latency:
  - Host read accepted at cycle N (cfg_valid & !cfg_we): cfg_rvalid = 1 at cycle N+1 with cfg_rdata = ram_spo.
  - Lookup accepted at cycle N: lk_rvalid = 1 at N+1 with lk_rdata = ram_dpo.
  - cfg_rdata and lk_rdata pass through combinationally from the RAM outputs. They are meaningful only while the matching rvalid is high.
  - Back-to-back requests run at 1 per cycle per port; no bubbles.
- Host write: cfg_rvalid is not asserted for writes.
- Collision: host write to address X and lookup of X in the same cycle returns the NEW data at N+1 (write-first). The controller does not stall either port.
- The last clear write and a first lookup one cycle later return 0.
- Address is not range-checked: addresses >= DEPTH are undefined, and the bench must not drive them.

Test Plan:
- Reset, release -> init_done low for exactly 64 cycles, ram_we high those 64 cycles with ram_a 0..63, ram_di 0; init_done high on cycle 65. Lookups of addr 0, 31 and 63 return 0.
- Host write 0x1A5B to addr 5, then host read of 5 next cycle -> cfg_rvalid one cycle after the read accept, cfg_rdata = 0x1A5B. No cfg_rvalid for the write.
- Same-cycle host write 0x7FFF to addr 9 and lookup of addr 9 -> lk_rvalid next cycle, lk_rdata = 0x7FFF. Streaming lookups 0..63 back-to-back -> 64 consecutive lk_rvalid pulses.
- Fill addrs 0..63 with the index value, pulse clr_req together with a lookup of addr 3 -> lookup returns 3. cfg_ready and lk_ready are low for 64 cycles, then all entries read 0.
- clr_req pulsed again mid-clear at clr_cnt = 20 -> ignored; clear still ends after 64 total cycles.
- Assert reset at clr_cnt = 40, and separately one cycle after a lookup accept -> no rvalid emitted; full 64-cycle clear restarts from addr 0.
